// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch unit for the 16-bit core. It owns the program counter,
// drives a synchronous instruction ROM (1-cycle read latency) and buffers up
// to DEPTH fetched instructions, each with its address. Decode takes them
// over a valid/ready handshake, so a decode stall only pauses fetching and
// never drops an instruction. A taken jump from execute flushes the queue,
// kills any ROM response arriving in the jump cycle, and redirects the PC.
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined   : when the queue is empty, a live ROM response is shown to
//               decode in the cycle it arrives. If decode accepts it in that
//               cycle it is never written into the queue.
//   undefined : every response is written into the queue first, so decode
//               sees it one cycle later. Order and content are the same.
//
// Parameters
//   DATA_W   instruction width
//   ADDR_W   instruction address width (PC wraps modulo 2**ADDR_W)
//   OFF_W    signed jump offset width
//   DEPTH    queue entries (power of two, >= 2)
//   RESET_PC PC value after reset
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   jump_en       taken jump from execute (single-cycle pulse)
//   jump_base_i   address of the jumping instruction
//   jump_offset   signed offset added to jump_base_i
//   rom_req_o     ROM read request this cycle
//   rom_addr_o    ROM read address
//   rom_data_i    ROM data for the request issued in the previous cycle
//   inst_o        head instruction for decode
//   inst_addr_o   address of inst_o
//   inst_valid_o  head entry valid
//   inst_ready_i  decode accepts the head entry
//   level_o       number of instructions held in the queue (0..DEPTH)
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int OFF_W    = 6,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    jump_en,
  input  logic [ADDR_W-1:0]       jump_base_i,
  input  logic [OFF_W-1:0]        jump_offset,
  output logic                    rom_req_o,
  output logic [ADDR_W-1:0]       rom_addr_o,
  input  logic [DATA_W-1:0]       rom_data_i,
  output logic [DATA_W-1:0]       inst_o,
  output logic [ADDR_W-1:0]       inst_addr_o,
  output logic                    inst_valid_o,
  input  logic                    inst_ready_i,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int SUM_W = (ADDR_W > OFF_W) ? ADDR_W : OFF_W;

  // Architectural state
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_d [DEPTH];

  // Per-cycle control
  logic [LVL_W:0]    occupancy;
  logic              issue;
  logic              resp_valid;
  logic              bypass;
  logic              pop;
  logic              head_pop;
  logic              push;
  logic [ADDR_W-1:0] jump_target;

  // Jump target: sign-extend the offset to the wider of the two operands,
  // then keep only ADDR_W bits so the target wraps like the PC does.
  always_comb begin
    jump_target = jump_base_i + ADDR_W'(SUM_W'($signed(jump_offset)));
  end

  // Issue rule. The in-flight request counts against capacity, which is
  // what guarantees a slot for every response and makes overflow impossible.
  always_comb begin
    occupancy = {1'b0, level_q} + (LVL_W + 1)'(inflight_q);
    issue     = ~rst & ~jump_en & (occupancy < (LVL_W + 1)'(DEPTH));
  end

  assign rom_req_o  = issue;
  assign rom_addr_o = pc_q;

  // A response arriving in a jump cycle belongs to the abandoned path.
  assign resp_valid = inflight_q & ~jump_en;

`ifdef FETCH_BYPASS_EN
  // An empty queue means the arriving response is the oldest instruction,
  // so it can be shown to decode straight away.
  assign bypass = resp_valid & (level_q == '0);
`else
  assign bypass = 1'b0;
`endif

  // Decode-facing outputs: the head slot of the queue, or the arriving
  // response while it is being bypassed.
  always_comb begin
    inst_valid_o = (level_q != '0) | bypass;
    inst_o       = bypass ? rom_data_i : data_mem_q[head_q];
    inst_addr_o  = bypass ? tag_q      : addr_mem_q[head_q];
  end

  assign level_o = level_q;

  // A pop in the jump cycle is ignored; the flush discards everything anyway.
  // A bypassed response that decode accepts never touches the storage.
  always_comb begin
    pop      = inst_valid_o & inst_ready_i & ~jump_en;
    head_pop = pop & ~bypass;
    push     = resp_valid & ~(bypass & inst_ready_i);
  end

  always_comb begin
    pc_d       = pc_q;
    inflight_d = 1'b0;
    tag_d      = tag_q;
    head_d     = head_q;
    tail_d     = tail_q;
    level_d    = level_q;
    data_mem_d = data_mem_q;
    addr_mem_d = addr_mem_q;

    if (jump_en) begin
      // Flush: emptying the pointers and level is enough, stale slot
      // contents are never visible while level is zero.
      pc_d    = jump_target;
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
    end else begin
      if (issue) begin
        pc_d       = pc_q + ADDR_W'(1);
        inflight_d = 1'b1;
        tag_d      = pc_q;
      end
      if (push) begin
        data_mem_d[tail_q] = rom_data_i;
        addr_mem_d[tail_q] = tag_q;
        tail_d             = tail_q + PTR_W'(1);
      end
      if (head_pop) begin
        head_d = head_q + PTR_W'(1);
      end
      level_d = level_q + LVL_W'(push) - LVL_W'(head_pop);
    end
  end

  // Storage slots are cleared on reset so inst_o/inst_addr_o read zero
  // after reset rather than whatever was left from before.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= ADDR_W'(RESET_PC);
      inflight_q <= 1'b0;
      tag_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      level_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        addr_mem_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      level_q    <= level_d;
      data_mem_q <= data_mem_d;
      addr_mem_q <= addr_mem_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Self-checking bench for fetch_queue (default parameters). A behavioural
// ROM answers requests one cycle later. The reference model keeps a list of
// fetched-but-not-delivered instructions, each stamped with the cycle it was
// requested; visibility to decode and queue level follow from those stamps.
// Inputs change 1 time unit after the rising edge, outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int OFF_W  = 6;
  localparam int DEPTH  = 4;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              jump_en = 1'b0;
  logic [ADDR_W-1:0] jump_base_i = '0;
  logic [OFF_W-1:0]  jump_offset = '0;
  logic              rom_req_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_data_i;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic              inst_valid_o;
  logic              inst_ready_i = 1'b0;
  logic [2:0]        level_o;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_queue dut (
    .clk          (clk),
    .rst          (rst),
    .jump_en      (jump_en),
    .jump_base_i  (jump_base_i),
    .jump_offset  (jump_offset),
    .rom_req_o    (rom_req_o),
    .rom_addr_o   (rom_addr_o),
    .rom_data_i   (rom_data_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .level_o      (level_o)
  );

  always #5 clk = ~clk;

  // Synchronous ROM; garbage on cycles without a request.
  logic [DATA_W-1:0] rom_mem [16];
  always @(posedge clk) begin
    if (rom_req_o) rom_data_i <= rom_mem[rom_addr_o];
    else           rom_data_i <= DATA_W'($urandom);
  end

  // Reference model state
  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                req_cyc;
  } ent_t;

  ent_t              pend[$];
  logic [ADDR_W-1:0] m_pc = '0;
  int                cyc = 0;

  function automatic logic m_req();
    return !rst && !jump_en && (pend.size() < DEPTH);
  endfunction

  function automatic logic m_valid();
    if (pend.size() == 0) return 1'b0;
    if (pend[0].req_cyc + 2 <= cyc) return 1'b1;
    return (LAT == 1) && (pend[0].req_cyc + 1 == cyc) && !jump_en;
  endfunction

  function automatic int m_level();
    int n = 0;
    foreach (pend[i]) if (pend[i].req_cyc + 2 <= cyc) n++;
    return n;
  endfunction

  function automatic logic [ADDR_W-1:0] m_target(logic [ADDR_W-1:0] base, logic [OFF_W-1:0] off);
    int o;
    o = off[OFF_W-1] ? int'(off) - 64 : int'(off);
    return ADDR_W'((((int'(base) + o) % 16) + 16) % 16);
  endfunction

  // Advance the model by one cycle using the current inputs, then the clock.
  task automatic tick();
    logic v, r, was_rst;
    ent_t e;
    v = m_valid();
    r = m_req();
    was_rst = rst;
    if (rst) begin
      pend.delete();
      m_pc = '0;
    end else if (jump_en) begin
      pend.delete();
      m_pc = m_target(jump_base_i, jump_offset);
    end else begin
      if (v && inst_ready_i) void'(pend.pop_front());
      if (r) begin
        e.addr = m_pc;
        e.req_cyc = cyc;
        pend.push_back(e);
        m_pc = m_pc + 4'd1;
      end
    end
    @(posedge clk);
    #1;
    cyc = was_rst ? 0 : cyc + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    jump_en = 1'b0;
    inst_ready_i = 1'b0;
    @(negedge clk);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    jump_en = 1'b0;
    inst_ready_i = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_cmp++; if (level_o !== 3'd0) begin n_bad++; $display("[TB] FAIL reset_level got %0d want 0", level_o); end
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid got %b want 0", inst_valid_o); end
    n_cmp++; if (inst_o !== 16'h0) begin n_bad++; $display("[TB] FAIL reset_inst got %h want 0000", inst_o); end
    n_cmp++; if (inst_addr_o !== 4'h0) begin n_bad++; $display("[TB] FAIL reset_inst_addr got %h want 0", inst_addr_o); end
    n_cmp++; if (rom_req_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_req got %b want 0", rom_req_o); end
    n_cmp++; if (rom_addr_o !== 4'h0) begin n_bad++; $display("[TB] FAIL reset_rom_addr got %h want 0", rom_addr_o); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    int first_valid;
    first_valid = -1;
    for (int a = 0; a < 16; a++) rom_mem[a] = 16'hA000 + 16'(a);
    do_reset();
    inst_ready_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (inst_valid_o && first_valid < 0) first_valid = cyc;
      n_cmp++; if (rom_req_o !== m_req()) begin n_bad++; $display("[TB] FAIL stream_req cyc %0d got %b want %b", cyc, rom_req_o, m_req()); end
      n_cmp++; if (inst_valid_o !== (cyc >= LAT)) begin n_bad++; $display("[TB] FAIL stream_valid cyc %0d got %b want %b", cyc, inst_valid_o, cyc >= LAT); end
      if (cyc >= LAT) begin
        n_cmp++; if (inst_addr_o !== 4'((cyc - LAT) % 16)) begin n_bad++; $display("[TB] FAIL stream_addr cyc %0d got %h want %h", cyc, inst_addr_o, 4'((cyc - LAT) % 16)); end
        n_cmp++; if (inst_o !== 16'hA000 + 16'((cyc - LAT) % 16)) begin n_bad++; $display("[TB] FAIL stream_data cyc %0d got %h want %h", cyc, inst_o, 16'hA000 + 16'((cyc - LAT) % 16)); end
      end
      n_cmp++; if (int'(level_o) !== m_level()) begin n_bad++; $display("[TB] FAIL stream_level cyc %0d got %0d want %0d", cyc, level_o, m_level()); end
      tick();
    end
    n_cmp++; if (first_valid !== LAT) begin n_bad++; $display("[TB] FAIL stream_first_valid got %0d want %0d", first_valid, LAT); end
  endtask

  task automatic test_stall();
    int nreq;
    nreq = 0;
    do_reset();
    inst_ready_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rom_req_o) begin
        n_cmp++; if (rom_addr_o !== 4'(nreq)) begin n_bad++; $display("[TB] FAIL stall_addr got %h want %h", rom_addr_o, 4'(nreq)); end
        nreq++;
      end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (nreq !== 4) begin n_bad++; $display("[TB] FAIL stall_req_count got %0d want 4", nreq); end
    n_cmp++; if (level_o !== 3'd4) begin n_bad++; $display("[TB] FAIL stall_level got %0d want 4", level_o); end
    n_cmp++; if (rom_req_o !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_req_full got %b want 0", rom_req_o); end
    n_cmp++; if (inst_addr_o !== 4'h0) begin n_bad++; $display("[TB] FAIL stall_head got %h want 0", inst_addr_o); end
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (rom_req_o !== 1'b1) begin n_bad++; $display("[TB] FAIL stall_resume_req got %b want 1", rom_req_o); end
    n_cmp++; if (rom_addr_o !== 4'h4) begin n_bad++; $display("[TB] FAIL stall_resume_addr got %h want 4", rom_addr_o); end
    n_cmp++; if (level_o !== 3'd3) begin n_bad++; $display("[TB] FAIL stall_after_pop_level got %0d want 3", level_o); end
    tick();
    @(negedge clk);
    n_cmp++; if (rom_req_o !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_single_req got %b want 0", rom_req_o); end
    tick();
  endtask

  task automatic test_jump();
    logic              found;
    int                got_cyc, jcyc;
    logic [ADDR_W-1:0] tgt, got_addr;
    logic [DATA_W-1:0] got_data;
    found = 1'b0; got_cyc = 0; got_addr = '0; got_data = '0;
    for (int a = 0; a < 16; a++) rom_mem[a] = 16'hA000 + 16'(a);
    do_reset();
    inst_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tick();
    end
    jump_en = 1'b1; jump_base_i = 4'd5; jump_offset = 6'h3D;
    tgt = m_target(4'd5, 6'h3D);
    jcyc = cyc;
    @(negedge clk);
    n_cmp++; if (level_o !== 3'd3) begin n_bad++; $display("[TB] FAIL jump_pre_level got %0d want 3", level_o); end
    n_cmp++; if (rom_req_o !== 1'b0) begin n_bad++; $display("[TB] FAIL jump_cycle_req got %b want 0", rom_req_o); end
    tick();
    jump_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (level_o !== 3'd0) begin n_bad++; $display("[TB] FAIL jump_flush_level got %0d want 0", level_o); end
    n_cmp++; if (rom_req_o !== 1'b1) begin n_bad++; $display("[TB] FAIL jump_redirect_req got %b want 1", rom_req_o); end
    n_cmp++; if (rom_addr_o !== tgt) begin n_bad++; $display("[TB] FAIL jump_redirect_addr got %h want %h", rom_addr_o, tgt); end
    tick();
    inst_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (inst_valid_o) begin
        found = 1'b1; got_cyc = cyc; got_addr = inst_addr_o; got_data = inst_o;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!found) begin
      n_bad++; $display("[TB] FAIL jump_first_valid_timeout got none want addr %h", tgt);
    end else begin
      if (got_addr !== tgt) begin n_bad++; $display("[TB] FAIL jump_first_addr got %h want %h", got_addr, tgt); end
      n_cmp++; if (got_data !== rom_mem[tgt]) begin n_bad++; $display("[TB] FAIL jump_first_data got %h want %h", got_data, rom_mem[tgt]); end
      n_cmp++; if (got_cyc !== jcyc + 1 + LAT) begin n_bad++; $display("[TB] FAIL jump_penalty got cyc %0d want %0d", got_cyc, jcyc + 1 + LAT); end
    end
    tick();
  endtask

  task automatic test_jump_full();
    logic              found;
    logic [ADDR_W-1:0] tgt, got_addr;
    found = 1'b0; got_addr = '0;
    do_reset();
    inst_ready_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      tick();
    end
    jump_en = 1'b1; jump_base_i = 4'd14; jump_offset = 6'd3; inst_ready_i = 1'b1;
    tgt = m_target(4'd14, 6'd3);
    @(negedge clk);
    n_cmp++; if (level_o !== 3'd4) begin n_bad++; $display("[TB] FAIL jfull_pre_level got %0d want 4", level_o); end
    tick();
    jump_en = 1'b0; inst_ready_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (level_o !== 3'd0) begin n_bad++; $display("[TB] FAIL jfull_flush_level got %0d want 0", level_o); end
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL jfull_flush_valid got %b want 0", inst_valid_o); end
    n_cmp++; if (rom_addr_o !== tgt) begin n_bad++; $display("[TB] FAIL jwrap_addr got %h want %h", rom_addr_o, tgt); end
    tick();
    inst_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (inst_valid_o) begin
        found = 1'b1; got_addr = inst_addr_o;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!found) begin
      n_bad++; $display("[TB] FAIL jwrap_first_valid_timeout got none want addr %h", tgt);
    end else if (got_addr !== tgt) begin
      n_bad++; $display("[TB] FAIL jwrap_first_addr got %h want %h", got_addr, tgt);
    end
    tick();
  endtask

  task automatic test_rst_jump();
    do_reset();
    inst_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tick();
    end
    rst = 1'b1; jump_en = 1'b1; jump_base_i = 4'd9; jump_offset = 6'd2;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_cmp++; if (level_o !== 3'd0) begin n_bad++; $display("[TB] FAIL rstjump_level got %0d want 0", level_o); end
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL rstjump_valid got %b want 0", inst_valid_o); end
    n_cmp++; if (inst_o !== 16'h0) begin n_bad++; $display("[TB] FAIL rstjump_inst got %h want 0000", inst_o); end
    n_cmp++; if (rom_addr_o !== 4'h0) begin n_bad++; $display("[TB] FAIL rstjump_pc got %h want 0", rom_addr_o); end
    tick();
    rst = 1'b0; jump_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (rom_req_o !== 1'b1 || rom_addr_o !== 4'h0) begin n_bad++; $display("[TB] FAIL rstjump_first_req got %b/%h want 1/0", rom_req_o, rom_addr_o); end
    tick();
  endtask

  task automatic test_random();
    for (int a = 0; a < 16; a++) rom_mem[a] = DATA_W'($urandom);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      inst_ready_i = ($urandom_range(0, 9) < 7);
      jump_en      = ($urandom_range(0, 19) == 0);
      jump_base_i  = ADDR_W'($urandom);
      jump_offset  = OFF_W'($urandom);
      rst          = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      if (!rst) begin
        n_cmp++; if (rom_req_o !== m_req()) begin n_bad++; $display("[TB] FAIL rand_req cyc %0d got %b want %b", cyc, rom_req_o, m_req()); end
        if (m_req()) begin
          n_cmp++; if (rom_addr_o !== m_pc) begin n_bad++; $display("[TB] FAIL rand_rom_addr cyc %0d got %h want %h", cyc, rom_addr_o, m_pc); end
        end
        n_cmp++; if (inst_valid_o !== m_valid()) begin n_bad++; $display("[TB] FAIL rand_valid cyc %0d got %b want %b", cyc, inst_valid_o, m_valid()); end
        if (m_valid()) begin
          n_cmp++; if (inst_addr_o !== pend[0].addr) begin n_bad++; $display("[TB] FAIL rand_inst_addr cyc %0d got %h want %h", cyc, inst_addr_o, pend[0].addr); end
          n_cmp++; if (inst_o !== rom_mem[pend[0].addr]) begin n_bad++; $display("[TB] FAIL rand_inst cyc %0d got %h want %h", cyc, inst_o, rom_mem[pend[0].addr]); end
        end
        n_cmp++; if (int'(level_o) !== m_level()) begin n_bad++; $display("[TB] FAIL rand_level cyc %0d got %0d want %0d", cyc, level_o, m_level()); end
      end
      tick();
    end
    rst = 1'b0; jump_en = 1'b0; inst_ready_i = 1'b0;
  endtask

  initial begin
    $display("[TB] fetch_queue bench start, fetch latency %0d", LAT);
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_jump_full();
    test_rst_jump();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
